serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer. It accepts one WIDTH-bit operation through a valid/ready handshake and drives a single 1-bit ALU slice (AND/OR/ADD/LESS slice with A/B invert and carry) across all bit positions, one bit per cycle. It holds the carry between cycles, assembles the result word, resolves SLT, and presents result, zero and overflow through an output valid/ready handshake. It is the area-minimal alternative to the ripple ALU in the lab datapath.

---
 rtl/serial_alu_ctrl.sv | 90 +++++++++
 tb/tb_serial_alu_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer driving one 1-bit slice per cycle.
// Define SERIAL_ALU_OVF_EN to compute signed overflow and use it to correct SLT.
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a, b, word, fin;
  logic [WIDTH-2:0] acc;
  logic [IW-1:0]    idx;
  logic             carry, a_inv, b_inv, known, ab, bb, sum, cout, r, ovf, set, last;
  logic [1:0]       op;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    a_inv = ctrl == 4'b1100;
    b_inv = ctrl inside {4'b0110, 4'b0111, 4'b1100};
    op    = ctrl == 4'b0001 ? 2'b01 : (ctrl inside {4'b0010, 4'b0110, 4'b0111}) ? 2'b10 : 2'b00;
    known = ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    ab    = a[0] ^ a_inv;
    bb    = b[0] ^ b_inv;
    sum   = ab ^ bb ^ carry;
    cout  = (ab & bb) | (carry & (ab ^ bb));
    r     = op == 2'b00 ? ab & bb : op == 2'b01 ? ab | bb : op == 2'b10 ? sum : 1'b0;
    word  = {r, acc};
`ifdef SERIAL_ALU_OVF_EN
    ovf   = carry ^ cout;
`else
    ovf   = 1'b0;
`endif
    set   = r ^ ovf;
    fin   = !known ? '0 : ctrl == 4'b0111 ? WIDTH'(set) : word;
    last  = idx == IW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ctrl  <= alu_ctrl;
          a     <= src_a;
          b     <= src_b;
          idx   <= '0;
          carry <= alu_ctrl inside {4'b0110, 4'b0111, 4'b1100};
          state <= RUN;
        end
        RUN: begin
          a     <= a >> 1;
          b     <= b >> 1;
          carry <= cout;
          acc   <= word[WIDTH-1:1];
          idx   <= last ? '0 : idx + IW'(1);
          if (last) begin
            result   <= fin;
            zero     <= fin == '0;
            overflow <= (ctrl inside {4'b0010, 4'b0110}) & ovf;
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for serial_alu_ctrl (WIDTH=32).
module tb_serial_alu_ctrl;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0]  alu_ctrl = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic        in_ready, out_valid, zero, overflow;
  logic [31:0] result;
  int checks = 0, errors = 0;
`ifdef SERIAL_ALU_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = c; src_a = a; src_b = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_done(output int n, output logic rdy_seen);
    n = 0; rdy_seen = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      rdy_seen |= in_ready;
    end
  endtask
  task automatic consume;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({result, zero, overflow} !== 34'd0) begin errors++; $display("FAIL reset_outputs got %h %b %b want 0 0 0", result, zero, overflow); end
    rst = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_add;
    int n; logic rs;
    start_op(4'b0010, 32'd5, 32'd7);
    wait_done(n, rs);
    checks++; if (n !== 32) begin errors++; $display("FAIL add_latency got %0d want 32", n); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL add_in_ready_run got %b want 0", rs); end
    checks++; if ({result, zero, overflow} !== {32'd12, 1'b0, 1'b0}) begin errors++; $display("FAIL add_5_7 got %h %b %b want 0000000c 0 0", result, zero, overflow); end
    consume();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_sub_nor;
    int n; logic rs;
    start_op(4'b0110, 32'd7, 32'd7);
    wait_done(n, rs);
    checks++; if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_7_7 got %h %b %b want 00000000 1 0", result, zero, overflow); end
    consume();
    start_op(4'b1100, 32'd0, 32'd0);
    wait_done(n, rs);
    checks++; if ({result, zero} !== {32'hFFFFFFFF, 1'b0}) begin errors++; $display("FAIL nor_0_0 got %h %b want ffffffff 0", result, zero); end
    consume();
  endtask
  task automatic test_overflow;
    int n; logic rs;
    start_op(4'b0010, 32'h7FFFFFFF, 32'd1);
    wait_done(n, rs);
    checks++; if ({result, zero, overflow} !== {32'h80000000, 1'b0, OVF}) begin errors++; $display("FAIL add_ovf got %h %b %b want 80000000 0 %b", result, zero, overflow, OVF); end
    consume();
  endtask
  task automatic test_slt;
    int n; logic rs;
    start_op(4'b0111, 32'hFFFFFFFF, 32'd1);
    wait_done(n, rs);
    checks++; if ({result, zero, overflow} !== {32'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL slt_neg1_1 got %h %b %b want 00000001 0 0", result, zero, overflow); end
    consume();
    start_op(4'b0111, 32'h7FFFFFFF, 32'h80000000);
    wait_done(n, rs);
    checks++; if ({result, zero, overflow} !== {31'd0, !OVF, OVF, 1'b0}) begin errors++; $display("FAIL slt_ovf_case got %h %b %b want %0d %b 0", result, zero, overflow, !OVF, OVF); end
    consume();
  endtask
  task automatic test_and_backpressure;
    int n; logic rs; logic ok;
    start_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    src_a = 32'h0; src_b = 32'h12345678; alu_ctrl = 4'b0001; in_valid = 1;
    wait_done(n, rs);
    in_valid = 0;
    checks++; if ({result, zero} !== {32'hF000F000, 1'b0}) begin errors++; $display("FAIL and_result got %h %b want f000f000 0", result, zero); end
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 32'hF000F000 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL and_backpressure got res=%h rdy=%b vld=%b want f000f000 0 1", result, in_ready, out_valid); end
    consume();
  endtask
  task automatic test_invalid_op;
    int n; logic rs;
    start_op(4'b0011, 32'd5, 32'd3);
    wait_done(n, rs);
    checks++; if (n !== 32) begin errors++; $display("FAIL bad_op_latency got %0d want 32", n); end
    checks++; if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL bad_op got %h %b %b want 00000000 1 0", result, zero, overflow); end
    consume();
  endtask
  task automatic test_reset_mid_run;
    int n; logic rs; logic seen;
    start_op(4'b0010, 32'd100, 32'd200);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_async got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1 rst = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_no_result got vld_seen=%b rdy=%b want 0 1", seen, in_ready); end
    start_op(4'b0010, 32'd2, 32'd3);
    wait_done(n, rs);
    checks++; if ({result, zero, overflow} !== {32'd5, 1'b0, 1'b0}) begin errors++; $display("FAIL add_after_abort got %h %b %b want 00000005 0 0", result, zero, overflow); end
    consume();
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub_nor();
    test_overflow();
    test_slt();
    test_and_backpressure();
    test_invalid_op();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
